sonar_scheduler: RTL and testbench
==================================

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter N_SENS, default 4: number of ultrasonic sensors sequenced.
REQ-002 Parameter TRIG_CYC, default 1000: trigger pulse width in clk cycles (10 us at 100 MHz).
REQ-003 Parameter TIMEOUT_CYC, default 3000000: slot timeout in cycles, counted from trigger start (30 ms).
REQ-004 Parameter GAP_CYC, default 100000: idle cycles between slots for echo decay (1 ms).
REQ-005 Parameter THRESH, default 100000: echo width in cycles below which a sensor reports crash.
REQ-006 Parameter CNT_W, default 22: width of the echo/slot counters; SHALL satisfy 2^CNT_W > TIMEOUT_CYC.
REQ-007 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-008 rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-009 enable  input  1  1 = run scheduling; 0 = stop after current slot.
REQ-010 sensor_mask  input  N_SENS  1 = sensor participates in rotation.
REQ-011 echo  input  N_SENS  raw asynchronous echo lines, one per sensor.
REQ-012 trigger  output  N_SENS  trigger pulse to each sensor, at most one bit high.
REQ-013 is_crash  output  N_SENS  registered per-sensor obstacle-too-close flag.
REQ-014 dist_cnt  output  CNT_W  last measured echo width in cycles.
REQ-015 dist_id  output  clog2(N_SENS)  sensor index of dist_cnt.
REQ-016 dist_valid  output  1  one-cycle strobe: dist_cnt/dist_id/timeout_err updated.
REQ-017 timeout_err  output  1  qualifies dist_valid: slot ended by timeout.
REQ-018 busy  output  1  high in any state except IDLE.

Function
REQ-019 Each echo bit SHALL pass a 2-flop synchronizer; all echo decisions use synchronized values only.
REQ-020 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
REQ-021 IDLE -> TRIG when enable=1 and sensor_mask!=0; selected sensor = first masked-in index after the last-served index, wrapping N_SENS-1 -> 0; first selection after reset starts search at index 0.
REQ-022 TRIG: trigger[id]=1 for exactly TRIG_CYC cycles, then -> WAIT_RISE; the slot counter starts at 0 on the first TRIG cycle.
REQ-023 WAIT_RISE: -> MEASURE on synchronized echo[id] low-to-high edge; a line already high on entry SHALL NOT count as an edge.
REQ-024 MEASURE: echo counter increments every cycle synchronized echo[id]=1, including the edge cycle; on the first low cycle the slot completes.
REQ-025 On completion: dist_cnt=echo counter, dist_id=id, timeout_err=0, dist_valid=1 for one cycle, is_crash[id]=(count<THRESH); other is_crash bits unchanged; -> GAP.
REQ-026 Timeout: if slot counter reaches TIMEOUT_CYC in WAIT_RISE or MEASURE: dist_cnt=all-ones, timeout_err=1, dist_valid=1, is_crash[id]=0; -> GAP.
REQ-027 Counters SHALL saturate at all-ones, never wrap.
REQ-028 GAP: wait GAP_CYC cycles, then -> TRIG with next sensor if enable=1 and mask!=0, else -> IDLE.
REQ-029 enable or sensor_mask changes SHALL only take effect at slot selection; an in-flight slot always completes.
REQ-030 Echo activity on non-selected sensors SHALL be ignored.
REQ-031 Masking out a sensor SHALL NOT clear its is_crash bit.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, trigger=0, is_crash=0, dist_cnt=0, dist_id=0, dist_valid=0, timeout_err=0, busy=0, all counters and synchronizers 0, last-served index = N_SENS-1.
REQ-033 Reset mid-slot SHALL drop trigger in the same instant and discard the measurement (no dist_valid).

Verification (TRIG_CYC=4, TIMEOUT_CYC=200, GAP_CYC=10, THRESH=20, N_SENS=4)
REQ-034 mask=4'b0001, echo[0] high 15 cycles after trigger falls -> trigger[0] high 4 cycles; dist_valid with dist_cnt=15, dist_id=0, is_crash[0]=1.
REQ-035 Same with echo width 30 -> dist_cnt=30, is_crash[0]=0, timeout_err=0.
REQ-036 mask=4'b1010, echo answers every slot -> trigger order 1,3,1,3; GAP of exactly 10 cycles between slots.
REQ-037 No echo on sensor 2 -> dist_valid at slot cycle 200 with timeout_err=1, dist_cnt=all-ones, is_crash[2]=0; echo held high through whole slot -> same result.
REQ-038 enable dropped during MEASURE -> slot completes with dist_valid, then IDLE, busy=0; mask=0 with enable=1 -> stays IDLE.
REQ-039 rst_n pulsed low in MEASURE -> all outputs 0 immediately, no dist_valid; after release first trigger on lowest masked-in sensor.

Source files
------------

// File: rtl/sonar_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sonar_scheduler
// Description : Round-robin sequencer for N_SENS ultrasonic ranging sensors.
//               Each slot fires one trigger pulse and waits for the echo rise.
//               It then measures the echo width, or gives up at the slot
//               timeout. The result is reported, and the slot is followed by
//               an idle gap so that residual echoes can decay.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               enable       - run scheduling (sampled only at slot selection)
//               sensor_mask  - per-sensor participation in the rotation
//               echo         - raw asynchronous echo lines
//               trigger      - trigger pulses, at most one bit high
//               is_crash     - per-sensor "obstacle too close" flags
//               dist_cnt     - last echo width in cycles (all-ones on timeout)
//               dist_id      - sensor index belonging to dist_cnt
//               dist_valid   - one-cycle strobe for dist_cnt/dist_id/timeout_err
//               timeout_err  - the reported slot ended by timeout
//               busy         - scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_scheduler #(
  parameter int N_SENS      = 4,
  parameter int TRIG_CYC    = 1000,
  parameter int TIMEOUT_CYC = 3000000,
  parameter int GAP_CYC     = 100000,
  parameter int THRESH      = 100000,
  parameter int CNT_W       = 22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [N_SENS-1:0]         sensor_mask,
  input  logic [N_SENS-1:0]         echo,
  output logic [N_SENS-1:0]         trigger,
  output logic [N_SENS-1:0]         is_crash,
  output logic [CNT_W-1:0]          dist_cnt,
  output logic [$clog2(N_SENS)-1:0] dist_id,
  output logic                      dist_valid,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int IDW = $clog2(N_SENS);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [31:0]      THRESH_U  = 32'(THRESH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t             state_q;
  logic [N_SENS-1:0]  echo_s1_q, echo_s2_q, echo_p_q;
  logic [IDW-1:0]     cur_id_q, last_id_q, next_id_d;
  logic [CNT_W-1:0]   slot_cnt_q, echo_cnt_q, gap_cnt_q;
  logic [N_SENS-1:0]  trigger_q, is_crash_q;
  logic [CNT_W-1:0]   dist_cnt_q;
  logic [IDW-1:0]     dist_id_q;
  logic               dist_valid_q, timeout_err_q;

  logic echo_sel, echo_rise, gap_done, start_slot, timeout_hit, listening;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      echo_p_q  <= '0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_p_q  <= echo_s2_q;
    end
  end

  // Next sensor: first masked-in index strictly after the last served one,
  // wrapping. Scanning from the farthest candidate down to the nearest lets
  // the nearest hit win.
  always_comb begin
    logic [31:0]       idx;
    logic [N_SENS-1:0] rot;
    next_id_d = last_id_q;
    idx       = '0;
    rot       = '0;
    for (int k = N_SENS; k >= 1; k--) begin
      idx = (32'(last_id_q) + 32'(k)) % 32'(N_SENS);
      rot = sensor_mask >> idx;
      if (rot[0]) next_id_d = IDW'(idx);
    end
  end

  assign echo_sel    = echo_s2_q[cur_id_q];
  // An edge needs the previous synchronized sample low, so a line that is
  // already high when listening starts never counts as a rise.
  assign echo_rise   = echo_s2_q[cur_id_q] & ~echo_p_q[cur_id_q];
  assign gap_done    = (gap_cnt_q == GAP_LAST);
  assign listening   = (state_q == S_WAIT_RISE) || (state_q == S_MEASURE);
  // The slot counter is 0 in the first trigger cycle; the timeout strobe then
  // lands exactly in slot cycle TIMEOUT_CYC.
  assign timeout_hit = listening && (slot_cnt_q >= TMO_LAST);
  assign start_slot  = enable && (|sensor_mask) &&
                       ((state_q == S_IDLE) || ((state_q == S_GAP) && gap_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_id_q      <= '0;
      last_id_q     <= IDW'(N_SENS - 1);
      slot_cnt_q    <= '0;
      echo_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      trigger_q     <= '0;
      is_crash_q    <= '0;
      dist_cnt_q    <= '0;
      dist_id_q     <= '0;
      dist_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      dist_valid_q <= 1'b0;
      if (start_slot) begin
        state_q    <= S_TRIG;
        cur_id_q   <= next_id_d;
        last_id_q  <= next_id_d;
        trigger_q  <= N_SENS'(1) << next_id_d;
        slot_cnt_q <= '0;
        echo_cnt_q <= '0;
        gap_cnt_q  <= '0;
      end else if (timeout_hit) begin
        // Timeout wins over a completion landing in the same cycle.
        dist_cnt_q           <= '1;
        dist_id_q            <= cur_id_q;
        timeout_err_q        <= 1'b1;
        dist_valid_q         <= 1'b1;
        is_crash_q[cur_id_q] <= 1'b0;
        gap_cnt_q            <= '0;
        state_q              <= S_GAP;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_TRIG: begin
            slot_cnt_q <= sat_inc(slot_cnt_q);
            if (slot_cnt_q == TRIG_LAST) begin
              trigger_q <= '0;
              state_q   <= S_WAIT_RISE;
            end
          end
          S_WAIT_RISE: begin
            slot_cnt_q <= sat_inc(slot_cnt_q);
            if (echo_rise) begin
              echo_cnt_q <= CNT_W'(1);  // the edge cycle itself counts
              state_q    <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            slot_cnt_q <= sat_inc(slot_cnt_q);
            if (echo_sel) begin
              echo_cnt_q <= sat_inc(echo_cnt_q);
            end else begin
              dist_cnt_q           <= echo_cnt_q;
              dist_id_q            <= cur_id_q;
              timeout_err_q        <= 1'b0;
              dist_valid_q         <= 1'b1;
              is_crash_q[cur_id_q] <= (32'(echo_cnt_q) < THRESH_U);
              gap_cnt_q            <= '0;
              state_q              <= S_GAP;
            end
          end
          S_GAP: begin
            gap_cnt_q <= sat_inc(gap_cnt_q);
            if (gap_done) state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign trigger     = trigger_q;
  assign is_crash    = is_crash_q;
  assign dist_cnt    = dist_cnt_q;
  assign dist_id     = dist_id_q;
  assign dist_valid  = dist_valid_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sonar_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sonar_scheduler
// Description : Scoreboard bench for sonar_scheduler. The stimulus side
//               predicts each slot's report from the sensor-rotation and
//               echo-width rules and queues it. A monitor pops and compares
//               on every dist_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonar_scheduler;

  localparam int N_SENS      = 4;
  localparam int TRIG_CYC    = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int GAP_CYC     = 10;
  localparam int THRESH      = 20;
  localparam int CNT_W       = 8;
  localparam int ALL_ONES    = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [3:0]        sensor_mask;
  logic [3:0]        echo;
  logic [3:0]        trigger;
  logic [3:0]        is_crash;
  logic [CNT_W-1:0]  dist_cnt;
  logic [1:0]        dist_id;
  logic              dist_valid;
  logic              timeout_err;
  logic              busy;

  sonar_scheduler #(
    .N_SENS(N_SENS), .TRIG_CYC(TRIG_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC(GAP_CYC), .THRESH(THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_mask(sensor_mask),
    .echo(echo), .trigger(trigger), .is_crash(is_crash), .dist_cnt(dist_cnt),
    .dist_id(dist_id), .dist_valid(dist_valid), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    int         cnt;
    bit         tmo;
    logic [3:0] crash;
    int         vcyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_x;
  int         checks = 0;
  int         failures = 0;
  int         last_m = N_SENS - 1;
  logic [3:0] crash_m = 4'b0;
  int         prev_valid_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Rotation rule: first masked-in sensor after the last served one, wrapping.
  function automatic int next_id(input int last, input logic [3:0] m);
    int idx;
    for (int k = 1; k <= N_SENS; k++) begin
      idx = (last + k) % N_SENS;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Monitor: every report must match the oldest prediction, including timing.
  always @(negedge clk) begin
    if (dist_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: actual=dist_valid required=no report (t=%0t)", $time);
      end else begin
        mon_x = sbq.pop_front();
        chk("dist_id", dist_id, mon_x.id);
        chk("dist_cnt", dist_cnt, mon_x.cnt);
        chk("timeout_err", timeout_err, mon_x.tmo);
        chk("is_crash", is_crash, mon_x.crash);
        chk("valid_cycle", cyc, mon_x.vcyc);
      end
    end
  end

  // One slot. kind: 0 = echo pulse of width w starting d cycles after the
  // trigger falls, 1 = no echo, 2 = echo held high for the whole slot.
  // rst_at >= 0 pulses reset in that slot cycle instead of finishing.
  task automatic run_slot(input int kind, input int d, input int w, input bit noise,
                          input bit chk_gap, input bit rnd_mask, input bit drop_en,
                          input int rst_at);
    int         id_e, t0, r, vc, cnt_e;
    bit         tmo_e;
    logic [3:0] e, oh;
    exp_t       x;
    id_e = next_id(last_m, sensor_mask);
    t0 = -1;
    for (int n = 0; n < 500; n++) begin
      if (trigger != 4'b0) begin
        t0 = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (t0 < 0) begin
      checks++;
      failures++;
      $display("FAIL trigger_start: actual=no trigger in 500 cycles required=trigger on sensor %0d", id_e);
      return;
    end
    if (chk_gap) chk("gap_cycles", t0 - prev_valid_cyc, GAP_CYC);
    chk("busy_in_slot", busy, 1);
    last_m = id_e;
    oh = 4'b0001 << id_e;
    r = TRIG_CYC + d;
    // Echo seen by the scheduler lags the pin by two synchronizer cycles.
    if (kind == 0 && r + w + 2 < TIMEOUT_CYC - 1) begin
      cnt_e = w; tmo_e = 1'b0; vc = r + w + 3;
    end else begin
      cnt_e = ALL_ONES; tmo_e = 1'b1; vc = TIMEOUT_CYC;
    end
    if (rst_at < 0) begin
      crash_m[id_e[1:0]] = !tmo_e && (cnt_e < THRESH);
      x.id = id_e; x.cnt = cnt_e; x.tmo = tmo_e; x.crash = crash_m; x.vcyc = t0 + vc;
      sbq.push_back(x);
    end
    for (int c = 0; c <= vc; c++) begin
      if (c <= TRIG_CYC) chk("trigger", trigger, (c < TRIG_CYC) ? oh : 4'b0);
      e = noise ? 4'($urandom) : 4'b0;
      case (kind)
        0:       e[id_e[1:0]] = (c >= r) && (c < r + w);
        2:       e[id_e[1:0]] = (c < vc);
        default: e[id_e[1:0]] = 1'b0;
      endcase
      if (c == vc) e = 4'b0;
      echo = e;
      if (rnd_mask && c == TRIG_CYC + 1) sensor_mask = 4'($urandom_range(1, 15));
      if (drop_en && c == r + 3) enable = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        echo  = 4'b0;
        #1;
        chk("rst_trigger", trigger, 0);
        chk("rst_dist_valid", dist_valid, 0);
        chk("rst_dist_cnt", dist_cnt, 0);
        chk("rst_is_crash", is_crash, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dist_id", dist_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        last_m  = N_SENS - 1;
        crash_m = 4'b0;
        return;
      end
      if (c < vc) begin
        @(posedge clk); #1;
      end
    end
    prev_valid_cyc = t0 + vc;
  endtask

  initial begin
    bit seen;
    int k, kind;
    rst_n = 1'b0; enable = 1'b0; sensor_mask = 4'b0; echo = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_trigger", trigger, 0);
    chk("reset_is_crash", is_crash, 0);
    chk("reset_dist_cnt", dist_cnt, 0);
    chk("reset_dist_id", dist_id, 0);
    chk("reset_dist_valid", dist_valid, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    sensor_mask = 4'b0001;
    enable = 1'b1;

    // Short echo flags a crash, a longer one clears it.
    run_slot(0, 0, 15, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_slot(0, 3, 30, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    // Two-sensor rotation with noise on the idle lines.
    sensor_mask = 4'b1010;
    for (int i = 0; i < 4; i++)
      run_slot(0, $urandom_range(0, 20), $urandom_range(5, 40), 1'b1, 1'b1, 1'b0, 1'b0, -1);

    // Timeouts: silent sensor, then a line stuck high.
    sensor_mask = 4'b0100;
    run_slot(1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_slot(2, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    // Disable during measurement: the slot still reports, then idle.
    sensor_mask = 4'b0010;
    run_slot(0, 2, 25, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    repeat (GAP_CYC + 1) begin @(posedge clk); #1; end
    chk("busy_after_disable", busy, 0);
    seen = 1'b0;
    repeat (30) begin
      if (trigger != 4'b0 || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("idle_while_disabled", seen, 0);
    sensor_mask = 4'b0;
    enable = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      if (trigger != 4'b0 || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("idle_mask_zero", seen, 0);

    // Reset in the middle of a measurement, then restart from the lowest sensor.
    sensor_mask = 4'b1100;
    run_slot(0, 2, 50, 1'b0, 1'b0, 1'b0, 1'b0, TRIG_CYC + 2 + 10);
    run_slot(0, 1, 12, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Randomized slots with changing masks and echo noise.
    for (int i = 0; i < 25; i++) begin
      k = $urandom_range(0, 9);
      kind = (k < 8) ? 0 : ((k == 8) ? 1 : 2);
      run_slot(kind, $urandom_range(0, 40), $urandom_range(1, 60), 1'b1, 1'b1, 1'b1, 1'b0, -1);
    end

    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running required=finished (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
